// File: rtl/sfx_sequencer_if.sv
// Event/sound bundle between the game logic (master) and the jingle sequencer (slave).
// freq is 10 bits wide so the 523 Hz note of the good-collision jingle fits.
interface sfx_sequencer_if;
  logic       goodColl;
  logic       badColl;
  logic       move;
  logic       mute;
  logic [9:0] freq;
  logic       playSound;
  logic       busy;
  logic [1:0] note_idx;

  modport master (
    output goodColl, badColl, move, mute,
    input  freq, playSound, busy, note_idx
  );

  modport slave (
    input  goodColl, badColl, move, mute,
    output freq, playSound, busy, note_idx
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Turns one-cycle game event pulses into timed multi-note jingles for the tone oscillator.
// Define SFX_SEQ_QUEUE_EN to keep one lower-priority event pending until the current jingle ends.
module sfx_sequencer #(
  parameter int TICK_W     = 8,
  parameter int GOOD_TICKS = 10,
  parameter int BAD_TICKS  = 15,
  parameter int MOVE_TICKS = 3,
  parameter int GAP_TICKS  = 1
) (
  input  logic           clk,
  input  logic           nRst,
  sfx_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;
  // Encoded in priority order so class comparison is a plain magnitude compare.
  typedef enum logic [1:0] {C_NONE, C_MOVE, C_GOOD, C_BAD} cls_e;

  localparam logic [TICK_W-1:0] GAP_LOAD = (GAP_TICKS > 0) ? TICK_W'(GAP_TICKS - 1) : '0;

  function automatic logic [TICK_W-1:0] note_load(cls_e c);
    case (c)
      C_BAD:   note_load = TICK_W'(BAD_TICKS - 1);
      C_GOOD:  note_load = TICK_W'(GOOD_TICKS - 1);
      default: note_load = TICK_W'(MOVE_TICKS - 1);
    endcase
  endfunction

  function automatic logic [9:0] note_freq(cls_e c, logic [1:0] i);
    case ({c, i})
      {C_BAD,  2'd0}: note_freq = 10'd311;
      {C_BAD,  2'd1}: note_freq = 10'd262;
      {C_GOOD, 2'd0}: note_freq = 10'd440;
      {C_GOOD, 2'd1}: note_freq = 10'd494;
      {C_GOOD, 2'd2}: note_freq = 10'd523;
      {C_MOVE, 2'd0}: note_freq = 10'd262;
      default:        note_freq = 10'd0;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(cls_e c);
    case (c)
      C_BAD:   last_idx = 2'd1;
      C_GOOD:  last_idx = 2'd2;
      default: last_idx = 2'd0;
    endcase
  endfunction

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  cls_e              ev_cls, start_cls;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [9:0]        freq_q, freq_d;
  logic              play_q, play_d;
  logic              busy_q, busy_d;
  logic              accept;
`ifdef SFX_SEQ_QUEUE_EN
  cls_e              pend_q, pend_d;
`endif

  always_comb begin
    if (bus.badColl)       ev_cls = C_BAD;
    else if (bus.goodColl) ev_cls = C_GOOD;
    else if (bus.move)     ev_cls = C_MOVE;
    else                   ev_cls = C_NONE;
  end

  assign accept = (ev_cls != C_NONE) && ((state_q == S_IDLE) || (ev_cls >= cls_q));

  always_comb begin
    // NOTE: every variable gets a hold/default value first, so no path through
    // this block can leave one unassigned and infer a latch.
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    freq_d    = freq_q;
    play_d    = play_q;
    busy_d    = busy_q;
    start_cls = C_NONE;
`ifdef SFX_SEQ_QUEUE_EN
    pend_d    = pend_q;
`endif

    if (bus.mute) begin
      state_d = S_IDLE;
      cls_d   = C_NONE;
      cnt_d   = '0;
      idx_d   = 2'd0;
      freq_d  = 10'd0;
      play_d  = 1'b0;
      busy_d  = 1'b0;
`ifdef SFX_SEQ_QUEUE_EN
      pend_d  = C_NONE;
`endif
    end else if (accept) begin
      start_cls = ev_cls;
`ifdef SFX_SEQ_QUEUE_EN
      pend_d    = C_NONE;
`endif
    end else if (state_q != S_IDLE) begin
`ifdef SFX_SEQ_QUEUE_EN
      // Only lower-priority events reach here; the best of them waits.
      if (ev_cls > pend_q) pend_d = ev_cls;
`endif
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (state_q == S_PLAY && idx_q == last_idx(cls_q)) begin
        state_d = S_IDLE;
        cls_d   = C_NONE;
        idx_d   = 2'd0;
        freq_d  = 10'd0;
        play_d  = 1'b0;
        busy_d  = 1'b0;
`ifdef SFX_SEQ_QUEUE_EN
        if (pend_d != C_NONE) begin
          start_cls = pend_d;
          pend_d    = C_NONE;
        end
`endif
      end else if (state_q == S_PLAY && GAP_TICKS > 0) begin
        state_d = S_GAP;
        play_d  = 1'b0;
        cnt_d   = GAP_LOAD;
      end else begin
        state_d = S_PLAY;
        idx_d   = idx_q + 2'd1;
        freq_d  = note_freq(cls_q, idx_q + 2'd1);
        play_d  = 1'b1;
        cnt_d   = note_load(cls_q);
      end
    end

    if (start_cls != C_NONE) begin
      state_d = S_PLAY;
      cls_d   = start_cls;
      cnt_d   = note_load(start_cls);
      idx_d   = 2'd0;
      freq_d  = note_freq(start_cls, 2'd0);
      play_d  = 1'b1;
      busy_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      freq_q  <= 10'd0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SFX_SEQ_QUEUE_EN
      pend_q  <= C_NONE;
`endif
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
`ifdef SFX_SEQ_QUEUE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.freq      = freq_q;
  assign bus.playSound = play_q;
  assign bus.busy      = busy_q;
  assign bus.note_idx  = idx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: segment table of per-cycle expectations fed
// through a scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_sfx_sequencer;

  localparam logic [3:0] EV_NONE = 4'b0000;
  localparam logic [3:0] EV_MOVE = 4'b0001;
  localparam logic [3:0] EV_GOOD = 4'b0010;
  localparam logic [3:0] EV_BAD  = 4'b0100;
  localparam logic [3:0] EV_MUTE = 4'b1000;

  // ev is applied on the first cycle of a segment only; the expected outputs
  // hold for all n cycles that follow each clock edge of the segment.
  typedef struct {
    string      name;
    logic [3:0] ev;
    logic [9:0] freq;
    logic       play;
    logic       busy;
    logic [1:0] idx;
    int         n;
  } seg_t;

  typedef struct {
    string      name;
    logic [9:0] freq;
    logic       play;
    logic       busy;
    logic [1:0] idx;
  } exp_t;

  logic clk  = 1'b0;
  logic nRst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  seg_t tbl[$];
  exp_t sb[$];

  sfx_sequencer_if bus();

  sfx_sequencer dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic seg_t seg(string nm, logic [3:0] ev, int f, logic p, logic b, int i, int n);
    seg_t s;
    s.name = nm;
    s.ev   = ev;
    s.freq = 10'(f);
    s.play = p;
    s.busy = b;
    s.idx  = 2'(i);
    s.n    = n;
    return s;
  endfunction

  function automatic exp_t zero_exp(string nm);
    exp_t e;
    e.name = nm;
    e.freq = 10'd0;
    e.play = 1'b0;
    e.busy = 1'b0;
    e.idx  = 2'd0;
    return e;
  endfunction

  task automatic check(exp_t e);
    n_tests++;
    if (bus.freq !== e.freq || bus.playSound !== e.play ||
        bus.busy !== e.busy || bus.note_idx !== e.idx) begin
      n_fail++;
      $display("FAIL %s: got freq=%0d play=%b busy=%b idx=%0d, want freq=%0d play=%b busy=%b idx=%0d",
               e.name, bus.freq, bus.playSound, bus.busy, bus.note_idx,
               e.freq, e.play, e.busy, e.idx);
    end
  endtask

  // One clock: drive inputs, queue the expectation, sample #1 after the edge.
  task automatic cycle(logic [3:0] ev, exp_t e);
    exp_t got_exp;
    {bus.mute, bus.badColl, bus.goodColl, bus.move} = ev;
    sb.push_back(e);
    @(posedge clk);
    #1;
    {bus.mute, bus.badColl, bus.goodColl, bus.move} = EV_NONE;
    got_exp = sb.pop_front();
    check(got_exp);
  endtask

  task automatic run_table();
    exp_t e;
    foreach (tbl[s]) begin
      for (int k = 0; k < tbl[s].n; k++) begin
        e.name = $sformatf("%s[%0d]", tbl[s].name, k);
        e.freq = tbl[s].freq;
        e.play = tbl[s].play;
        e.busy = tbl[s].busy;
        e.idx  = tbl[s].idx;
        cycle((k == 0) ? tbl[s].ev : EV_NONE, e);
      end
    end
    tbl.delete();
  endtask

  // Gap after the 440 Hz note, then the 494 and 523 Hz notes.
  task automatic add_good_tail(string nm);
    tbl.push_back(seg({nm, "_gap0"}, EV_NONE, 440, 0, 1, 0, 1));
    tbl.push_back(seg({nm, "_494"},  EV_NONE, 494, 1, 1, 1, 10));
    tbl.push_back(seg({nm, "_gap1"}, EV_NONE, 494, 0, 1, 1, 1));
    tbl.push_back(seg({nm, "_523"},  EV_NONE, 523, 1, 1, 2, 10));
  endtask

  initial begin
    {bus.mute, bus.badColl, bus.goodColl, bus.move} = EV_NONE;
    #1 nRst = 1'b0;
    #1 check(zero_exp("reset_state"));
    #10 nRst = 1'b1;

    tbl.push_back(seg("idle", EV_NONE, 0, 0, 0, 0, 20));

    tbl.push_back(seg("good_440", EV_GOOD, 440, 1, 1, 0, 10));
    add_good_tail("good");
    tbl.push_back(seg("good_end", EV_NONE, 0, 0, 0, 0, 3));

    tbl.push_back(seg("pre_440", EV_GOOD, 440, 1, 1, 0, 5));
    tbl.push_back(seg("pre_311", EV_BAD,  311, 1, 1, 0, 15));
    tbl.push_back(seg("pre_gap", EV_NONE, 311, 0, 1, 0, 1));
    tbl.push_back(seg("pre_262", EV_NONE, 262, 1, 1, 1, 15));
    tbl.push_back(seg("pre_end", EV_NONE, 0, 0, 0, 0, 3));

    tbl.push_back(seg("sim_440", EV_GOOD | EV_MOVE, 440, 1, 1, 0, 10));
    add_good_tail("sim");
    tbl.push_back(seg("sim_end", EV_NONE, 0, 0, 0, 0, 4));

    tbl.push_back(seg("mv_440a", EV_GOOD, 440, 1, 1, 0, 3));
    tbl.push_back(seg("mv_440b", EV_MOVE, 440, 1, 1, 0, 7));
    add_good_tail("mv");
`ifdef SFX_SEQ_QUEUE_EN
    tbl.push_back(seg("mv_blip", EV_NONE, 262, 1, 1, 0, 3));
    tbl.push_back(seg("mv_end",  EV_NONE, 0, 0, 0, 0, 3));
`else
    tbl.push_back(seg("mv_end",  EV_NONE, 0, 0, 0, 0, 6));
`endif

    tbl.push_back(seg("blip",     EV_MOVE, 262, 1, 1, 0, 3));
    tbl.push_back(seg("blip_end", EV_NONE, 0, 0, 0, 0, 2));

    tbl.push_back(seg("rst_440a", EV_GOOD, 440, 1, 1, 0, 4));
    tbl.push_back(seg("rst_440b", EV_GOOD, 440, 1, 1, 0, 10));
    tbl.push_back(seg("rst_gap",  EV_NONE, 440, 0, 1, 0, 1));
    tbl.push_back(seg("rst_494",  EV_NONE, 494, 1, 1, 1, 1));
    tbl.push_back(seg("rst_mute", EV_MUTE, 0, 0, 0, 0, 3));

    tbl.push_back(seg("mute_311", EV_BAD,           311, 1, 1, 0, 2));
    tbl.push_back(seg("mute_off", EV_MUTE,          0, 0, 0, 0, 1));
    tbl.push_back(seg("mute_bad", EV_MUTE | EV_BAD, 0, 0, 0, 0, 1));
    tbl.push_back(seg("mute_end", EV_NONE,          0, 0, 0, 0, 3));

    tbl.push_back(seg("pend_311a", EV_BAD,  311, 1, 1, 0, 3));
    tbl.push_back(seg("pend_311b", EV_MOVE, 311, 1, 1, 0, 3));
    tbl.push_back(seg("pend_311c", EV_GOOD, 311, 1, 1, 0, 9));
    tbl.push_back(seg("pend_gap",  EV_NONE, 311, 0, 1, 0, 1));
    tbl.push_back(seg("pend_262",  EV_NONE, 262, 1, 1, 1, 15));
`ifdef SFX_SEQ_QUEUE_EN
    tbl.push_back(seg("pend_440",  EV_NONE, 440, 1, 1, 0, 10));
    add_good_tail("pend");
`endif
    tbl.push_back(seg("pend_end",  EV_NONE, 0, 0, 0, 0, 4));

    run_table();

    // Asynchronous reset in the middle of a note, then clean restart.
    tbl.push_back(seg("ar_440", EV_GOOD, 440, 1, 1, 0, 4));
    run_table();
    #2 nRst = 1'b0;
    #1 check(zero_exp("async_reset"));
    @(posedge clk);
    #1 check(zero_exp("reset_held"));
    #2 nRst = 1'b1;
    tbl.push_back(seg("ar_idle", EV_NONE, 0, 0, 0, 0, 5));
    tbl.push_back(seg("ar_blip", EV_MOVE, 262, 1, 1, 0, 3));
    tbl.push_back(seg("ar_end",  EV_NONE, 0, 0, 0, 0, 2));
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
